weight_seq_ctrl: RTL

Controller that sequences one neuron pass over a per-neuron weight memory (numWeight entries × dataWidth bits). Activations are accepted on a valid/ready stream, each is paired with its weight by issuing a read to the memory, and aligned (activation, weight) pairs are forwarded to the neuron MAC with a last marker. The block sits between the layer input stream and the neuron's weight memory / MAC. Weight loading into the memory can optionally be compiled in.

---
 rtl/fnn_ctrl_pkg.sv | 13 +
 rtl/wrap_counter.sv | 29 ++
 rtl/weight_seq_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fnn_ctrl_pkg.sv
// Shared types and defaults for the neuron weight sequencing controller.
package fnn_ctrl_pkg;

  localparam int unsigned DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/wrap_counter.sv
// Counter that runs 0..MAX and wraps to 0; synchronous clear has priority over increment.
module wrap_counter #(
  parameter int unsigned MAX   = 9,
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [Width-1:0] cnt,
  output logic             at_max
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= at_max ? '0 : cnt_q + Width'(1);
    end
  end

  assign cnt    = cnt_q;
  assign at_max = (cnt_q == Width'(MAX));

endmodule

// File: rtl/weight_seq_ctrl.sv
// Sequences one neuron pass: pairs each accepted activation with its weight for the MAC.
// Optional weight loading through the cfg stream is compiled in with WEIGHT_LOAD_EN.
module weight_seq_ctrl
  import fnn_ctrl_pkg::*;
#(
  parameter int unsigned numWeight    = 10,
  parameter int unsigned addressWidth = $clog2(numWeight),
  parameter int unsigned dataWidth    = DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  input  logic                    x_valid,
  output logic                    x_ready,
  input  logic [dataWidth-1:0]    x_in,
  output logic                    mem_ren,
  output logic [addressWidth-1:0] mem_radd,
  input  logic [dataWidth-1:0]    mem_wout,
  output logic                    mac_valid,
  output logic [dataWidth-1:0]    mac_x,
  output logic [dataWidth-1:0]    mac_w,
  output logic                    mac_last,
  output logic                    done,
  output logic                    mem_wen,
  output logic [addressWidth-1:0] mem_wadd,
  output logic [dataWidth-1:0]    mem_win,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [dataWidth-1:0]    cfg_data
);

  state_e state_q, state_d;

  logic                    accept;
  logic                    rd_clr;
  logic                    rd_at_max;
  logic [addressWidth-1:0] rd_cnt;
  logic [dataWidth-1:0]    x_q;
  logic                    v_q;
  logic                    last_q;

  assign x_ready = (state_q == StRun);
  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign accept  = x_valid & x_ready;
  assign rd_clr  = (state_q == StIdle) & start;

  wrap_counter #(
    .MAX   (numWeight - 1),
    .Width (addressWidth)
  ) u_rd_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (rd_clr),
    .inc    (accept),
    .cnt    (rd_cnt),
    .at_max (rd_at_max)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      v_q     <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= accept;
      last_q  <= accept & rd_at_max;
      if (accept) begin
        x_q <= x_in;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (accept && rd_at_max) state_d = StDrain;
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign mem_ren   = accept;
  assign mem_radd  = rd_cnt;
  assign mac_valid = v_q;
  assign mac_x     = x_q;
  assign mac_w     = mem_wout;
  assign mac_last  = v_q & last_q;

`ifdef WEIGHT_LOAD_EN
  logic                    wr;
  logic                    wr_at_max;
  logic [addressWidth-1:0] wr_cnt;

  // start wins over a pending cfg word; cfg_ready is also held low during reset
  assign cfg_ready = ~rst & (state_q == StIdle) & ~start;
  assign wr        = cfg_valid & cfg_ready;
  assign mem_wen   = wr;
  assign mem_wadd  = wr ? wr_cnt : '0;
  assign mem_win   = wr ? cfg_data : '0;

  wrap_counter #(
    .MAX   (numWeight - 1),
    .Width (addressWidth)
  ) u_wr_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (1'b0),
    .inc    (wr),
    .cnt    (wr_cnt),
    .at_max (wr_at_max)
  );

  logic unused_wr;
  assign unused_wr = wr_at_max;
`else
  assign cfg_ready = 1'b0;
  assign mem_wen   = 1'b0;
  assign mem_wadd  = '0;
  assign mem_win   = '0;

  logic unused_cfg;
  assign unused_cfg = ^{cfg_valid, cfg_data};
`endif

endmodule
